// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg
// Shared types and constants for the decoupled instruction fetch stage.
//   WIDTH         : data/address width
//   FETCH_DEPTH   : default prefetch queue depth
//   DISC_W        : width of the stale-response discard counter
//   fetch_entry_t : one prefetch queue slot {pc, instr, filled}
package ifetch_queue_pkg;

  localparam int WIDTH       = 32;
  localparam int FETCH_DEPTH = 4;
  // Discards are bounded by in-flight imem responses, which stay small;
  // 8 bits leaves ample room for chains of back-to-back redirects.
  localparam int DISC_W      = 8;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
    logic             filled;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fetch_queue.sv
// fetch_queue
// In-order circular prefetch buffer. A slot is allocated when its fetch
// request is accepted, filled when the matching response returns, and
// popped by decode. Pointers carry an extra wrap bit so that full/empty
// and counts fall out of plain subtraction.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_flush         : drop every entry and rewind all pointers
//   i_alloc         : allocate the next slot with PC i_alloc_pc
//   i_fill          : write i_fill_instr into the oldest unfilled slot
//   i_pop           : retire the head slot
//   o_full          : DEPTH slots allocated
//   o_outstanding   : allocated-but-unfilled slots (requests in flight)
//   o_head          : head slot contents
module fetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [WIDTH-1:0]         i_alloc_pc,
  input  logic                     i_fill,
  input  logic [WIDTH-1:0]         i_fill_instr,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_outstanding,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW:0]  r_alloc;
  logic [AW:0]  r_fill;
  logic [AW:0]  r_head;
  logic [AW:0]  w_used;

  assign w_used        = r_alloc - r_head;
  assign o_full        = (w_used == (AW+1)'(DEPTH));
  assign o_outstanding = r_alloc - r_fill;
  assign o_head        = r_mem[r_head[AW-1:0]];

  // The caller never allocates when full and never fills with nothing
  // outstanding, so alloc/fill/pop always touch distinct slots.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_head  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_alloc) begin
        r_mem[r_alloc[AW-1:0]].pc     <= i_alloc_pc;
        r_mem[r_alloc[AW-1:0]].filled <= 1'b0;
        r_alloc                       <= r_alloc + 1'b1;
      end
      if (i_fill) begin
        r_mem[r_fill[AW-1:0]].instr  <= i_fill_instr;
        r_mem[r_fill[AW-1:0]].filled <= 1'b1;
        r_fill                       <= r_fill + 1'b1;
      end
      // Clearing filled on pop keeps a recycled head slot from looking
      // valid before it is allocated again.
      if (i_pop) begin
        r_mem[r_head[AW-1:0]].filled <= 1'b0;
        r_head                       <= r_head + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue
// Decoupled fetch stage in front of decode. Issues word-aligned fetch
// requests to a variable-latency imem, buffers responses in an in-order
// prefetch queue and presents them to decode. A redirect flushes the
// queue, restarts fetch at the new PC and arms a counter that swallows
// the responses still in flight for the abandoned stream.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/addr/ready        : fetch request handshake
//   imem_rsp_valid/instr             : in-order responses, no backpressure
//   redirect_valid/pc                : flush and restart fetch
//   out_valid/instr/pc, out_ready    : head instruction handshake to decode
// Handshakes: a transfer happens in exactly the cycle where valid and
// ready are both high; valid never depends on ready. imem responses have
// no ready and are consumed (kept or discarded) in the cycle they appear.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int               DEPTH    = FETCH_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_instr,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_fetch_pc;
  logic [DISC_W-1:0] r_discard;

  logic              w_full;
  logic [AW:0]       w_outstanding;
  fetch_entry_t      w_head;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_fill;
  logic              w_pop;
  logic              w_rsp_live;
  logic [DISC_W-1:0] w_disc_redirect;
  logic [WIDTH-1:0]  w_redirect_pc;

  assign w_req_valid    = !rst && !w_full && !redirect_valid;
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = w_req_valid ? r_fetch_pc : '0;
  assign w_accept       = w_req_valid && imem_req_ready;

  // A response only counts if something is waiting for it (either a
  // discard or an allocated slot); anything else is an imem leftover.
  assign w_rsp_live = imem_rsp_valid && ((r_discard != '0) || (w_outstanding != '0));
  assign w_fill     = !rst && !redirect_valid && imem_rsp_valid &&
                      (r_discard == '0) && (w_outstanding != '0);

  assign out_valid = !rst && w_head.filled;
  assign out_instr = out_valid ? w_head.instr : '0;
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign w_pop     = out_valid && out_ready && !redirect_valid;

  // Everything in flight becomes stale on a redirect; a response landing
  // in the same cycle is one of those and is dropped right away.
  assign w_disc_redirect = r_discard + DISC_W'(w_outstanding) - DISC_W'(w_rsp_live);
  assign w_redirect_pc   = redirect_pc & ~WIDTH'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_discard  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_discard  <= w_disc_redirect;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
      if (imem_rsp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (redirect_valid),
    .i_alloc       (w_accept),
    .i_alloc_pc    (r_fetch_pc),
    .i_fill        (w_fill),
    .i_fill_instr  (imem_rsp_instr),
    .i_pop         (w_pop),
    .o_full        (w_full),
    .o_outstanding (w_outstanding),
    .o_head        (w_head)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
// Bench for ifetch_queue: an in-order variable-latency imem model feeds the
// DUT while a queue-level reference model of the fetch stage predicts every
// output each cycle.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  // ---------------- imem model ----------------
  typedef struct {
    logic [31:0] instr;
    int          due;
  } rsp_t;
  rsp_t imem_q[$];
  int   last_due;
  int   lat;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] pend_q[$];       // accepted requests awaiting a response
  logic [31:0] exp_pc_q[$];     // filled entries, in decode order
  logic [31:0] exp_instr_q[$];
  logic [31:0] m_fetch_pc;
  int          m_disc;

  int cyc;
  int n_pass;
  int n_total;

  // last observed DUT values, for directed checks
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_ov;
  logic [31:0] obs_pc;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_pc_q.delete();
    exp_instr_q.delete();
    m_fetch_pc = RESET_PC;
    m_disc     = 0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic cycle(input bit r, input bit rdy, input bit ordy,
                       input bit redir, input logic [31:0] rpc);
    bit          rsp;
    logic [31:0] rsp_instr;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    int          due;

    rst            = r;
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp            = 1'b0;
    rsp_instr      = 32'h0;
    if (imem_q.size() > 0 && imem_q[0].due == cyc) begin
      rsp       = 1'b1;
      rsp_instr = imem_q[0].instr;
      void'(imem_q.pop_front());
    end
    imem_rsp_valid = rsp;
    imem_rsp_instr = rsp_instr;

    e_req   = !r && !redir && (pend_q.size() + exp_pc_q.size() < DEPTH);
    e_addr  = e_req ? m_fetch_pc : 32'h0;
    e_ov    = !r && (exp_pc_q.size() > 0);
    e_pc    = 32'h0;
    e_instr = 32'h0;
    if (e_ov) begin
      e_pc    = exp_pc_q[0];
      e_instr = exp_instr_q[0];
    end

    #4;
    obs_req  = imem_req_valid;
    obs_addr = imem_req_addr;
    obs_ov   = out_valid;
    obs_pc   = out_pc;
    check("req_valid", 32'(imem_req_valid), 32'(e_req));
    check("req_addr",  imem_req_addr, e_addr);
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("out_pc",    out_pc, e_pc);
    check("out_instr", out_instr, e_instr);

    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (redir) begin
      m_disc = pend_q.size() + m_disc - ((rsp && (pend_q.size() + m_disc > 0)) ? 1 : 0);
      pend_q.delete();
      exp_pc_q.delete();
      exp_instr_q.delete();
      m_fetch_pc = rpc & ~32'd3;
    end else begin
      if (e_ov && ordy) begin
        void'(exp_pc_q.pop_front());
        void'(exp_instr_q.pop_front());
      end
      if (rsp) begin
        if (m_disc > 0) begin
          m_disc--;
        end else if (pend_q.size() > 0) begin
          exp_pc_q.push_back(pend_q.pop_front());
          exp_instr_q.push_back(rsp_instr);
        end
      end
      if (e_req && rdy) begin
        pend_q.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    // imem keeps serving accepted requests regardless of later resets
    if (e_req && rdy) begin
      due = imax(last_due + 1, cyc + lat);
      imem_q.push_back('{instr: $urandom, due: due});
      last_due = due;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first;
    int  accepts;
    bit  found;
    bit  r;

    n_pass   = 0;
    n_total  = 0;
    cyc      = 0;
    lat      = 1;
    last_due = -100;
    model_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_instr = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // reset: all outputs low
    repeat (3) cycle(1, 1, 1, 0, 32'h0);

    // streaming, imem always ready, 1-cycle latency
    first = -1;
    for (int k = 0; k < 14; k++) begin
      cycle(0, 1, 1, 0, 32'h0);
      if (obs_ov && first < 0) first = k;
    end
    check("first_valid_cycle", 32'(first), 32'd2);

    // decode stalled: exactly DEPTH requests accepted, then fetch stops
    cycle(1, 1, 1, 0, 32'h0);
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 0, 0, 32'h0);
      if (obs_req) accepts++;
    end
    check("stall_accepts", 32'(accepts), 32'd4);
    check("stall_req_low", 32'(obs_req), 32'd0);
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0, 32'h0);

    // 3-cycle latency, redirect with responses in flight
    lat = 3;
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 0, 32'h0);
    cycle(0, 1, 1, 1, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 1, 0, 32'h0);
      if (obs_ov) begin
        check("redirect_first_pc", obs_pc, 32'h100);
        found = 1'b1;
        break;
      end
    end
    check("redirect_found", 32'(found), 32'd1);

    // redirect coincident with a response and out_ready high
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_q.size() > 0 && imem_q[0].due == cyc) begin
        cycle(0, 1, 1, 1, 32'h200);
        found = 1'b1;
        break;
      end
      cycle(0, 1, 1, 0, 32'h0);
    end
    check("coincident_found", 32'(found), 32'd1);
    for (int k = 0; k < 12; k++) cycle(0, 1, 1, 0, 32'h0);

    // request ready pattern 1,0,0,1
    lat = 1;
    for (int k = 0; k < 16; k++) cycle(0, (k % 4 == 0) || (k % 4 == 3), 1, 0, 32'h0);

    // misaligned redirect near the top of the address space, then wrap
    cycle(0, 1, 1, 1, 32'hFFFF_FFFF);
    cycle(0, 1, 1, 0, 32'h0);
    check("wrap_addr_top", obs_addr, 32'hFFFF_FFFC);
    cycle(0, 1, 1, 0, 32'h0);
    check("wrap_addr_zero", obs_addr, 32'h0000_0000);
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 0, 32'h0);

    // reset mid-stream with responses still arriving afterwards
    lat = 2;
    for (int k = 0; k < 6; k++) cycle(0, 1, 1, 0, 32'h0);
    cycle(1, 1, 1, 0, 32'h0);
    cycle(0, 1, 1, 0, 32'h0);
    check("restart_req", 32'(obs_req), 32'd1);
    check("restart_addr", obs_addr, RESET_PC);
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0, 32'h0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      lat = $urandom_range(1, 4);
      r   = ($urandom_range(0, 99) == 0);
      cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom);
    end
    for (int k = 0; k < 12; k++) cycle(0, 1, 1, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
